uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the core's data-memory bus, replacing the simulation-only console sink at the store-to-console address. CPU byte stores to the TX data register are buffered in a FIFO and serialised 8N1 on `tx`. A status register lets firmware poll for space and completion. The status read data and a hit flag feed the testbench/SoC read-data mux, in the same way the timer value is muxed in.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_mmio.sv | 153 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic [31:0] DEF_TX_ADDR   = 32'hFFFF_FFFC;
  localparam logic [31:0] DEF_STAT_ADDR = 32'hFFFF_FFF8;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, first-word-fall-through dout, count is DEPTH+1 valued.
// Push while full is accepted only together with a pop; otherwise it is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: byte stores to TX_ADDR are queued and sent 8N1; start bit 1 cycle after the write.
// A store to a full FIFO (with no pop that cycle) is dropped and sets sticky ovf; no bus stall.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] TX_ADDR    = DEF_TX_ADDR,
  parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  input  logic        wEn,
  output logic [31:0] rData,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam int            NW      = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  tx_state_e     state, stateNext;
  logic [CW-1:0] bitCnt, bitCntNext;
  logic [2:0]    idx, idxNext;
  logic [7:0]    shreg, shregNext;
  logic          txNext;
  logic          pop;
  logic          ovf;
  logic          txHit, statHit, txPush;
  logic [7:0]    fifoDout;
  logic          fifoFull, fifoEmpty;
  logic [NW-1:0] fifoCount;
  logic [31:0]   status;
  logic          unusedWData;

  assign txHit       = (addr == TX_ADDR);
  assign statHit     = (addr == STAT_ADDR);
  assign hit         = txHit || statHit;
  assign txPush      = wEn && txHit;
  assign busy        = !fifoEmpty || (state != IDLE);
  assign unusedWData = ^wData[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (txPush),
    .pop   (pop),
    .din   (wData[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (txPush && fifoFull && !pop) begin
      ovf <= 1'b1;
    end else if (wEn && statHit && wData[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    status                   = '0;
    status[ST_BUSY]          = busy;
    status[ST_FULL]          = fifoFull;
    status[ST_EMPTY]         = fifoEmpty;
    status[ST_OVF]           = ovf;
    status[ST_CNT_LSB +: 8]  = 8'(fifoCount);
    rData                    = statHit ? status : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      bitCnt <= '0;
      idx    <= '0;
      shreg  <= '0;
      tx     <= 1'b1;
    end else begin
      state  <= stateNext;
      bitCnt <= bitCntNext;
      idx    <= idxNext;
      shreg  <= shregNext;
      tx     <= txNext;
    end
  end

  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    idxNext    = idx;
    shregNext  = shreg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          pop        = 1'b1;
          shregNext  = fifoDout;
          bitCntNext = CNT_MAX;
          stateNext  = START;
        end
      end
      START: begin
        if (bitCnt == '0) begin
          stateNext  = DATA;
          idxNext    = '0;
          bitCntNext = CNT_MAX;
        end else begin
          bitCntNext = bitCnt - CW'(1);
        end
      end
      DATA: begin
        if (bitCnt == '0) begin
          bitCntNext = CNT_MAX;
          if (idx == 3'd7) stateNext = STOP;
          else             idxNext   = idx + 3'd1;
        end else begin
          bitCntNext = bitCnt - CW'(1);
        end
      end
      STOP: begin
        // Chain straight into the next start bit so back-to-back frames have no gap.
        if (bitCnt == '0) begin
          if (!fifoEmpty) begin
            pop        = 1'b1;
            shregNext  = fifoDout;
            bitCntNext = CNT_MAX;
            stateNext  = START;
          end else begin
            stateNext  = IDLE;
          end
        end else begin
          bitCntNext = bitCnt - CW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shregNext[idxNext];
      default: txNext = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio (CLK_DIV=4, FIFO_DEPTH=4): scoreboard of written bytes checked
// against a serial monitor, plus cycle-exact latency, status and decode checks.
module tb_uart_tx_mmio;

  localparam logic [31:0] TXA = 32'hFFFF_FFFC;
  localparam logic [31:0] STA = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h100;
  logic [31:0] wData = '0;
  logic        wEn = 1'b0;
  logic [31:0] rData;
  logic        hit, tx, busy;

  uart_tx_mmio #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4),
    .TX_ADDR    (TXA),
    .STAT_ADDR  (STA)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wData (wData),
    .wEn   (wEn),
    .rData (rData),
    .hit   (hit),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         nChecks = 0;
  int         nErrors = 0;
  logic [7:0] sb [$];
  int         frameCount = 0;
  int         lastStart = -1;
  int         lastWr = 0;
  logic       monBusy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Serial monitor: every sample of a frame is compared against the byte at the head of the scoreboard.
  initial begin
    int         monCnt;
    int         slot;
    logic       expBit;
    logic [7:0] expByte;
    logic [7:0] rxByte;
    monCnt  = 0;
    expByte = '0;
    rxByte  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        monBusy = 1'b0;
      end else begin
        if (!monBusy && tx == 1'b0) begin
          monBusy   = 1'b1;
          monCnt    = 0;
          lastStart = cyc;
          rxByte    = '0;
          check("frame expected", 32'(sb.size() > 0), 32'd1);
          expByte = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        end
        if (monBusy) begin
          slot   = monCnt / 4;
          expBit = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : expByte[slot-1];
          check("tx bit", 32'(tx), 32'(expBit));
          if (monCnt % 4 == 2 && slot >= 1 && slot <= 8) rxByte[slot-1] = tx;
          if (monCnt == 39) begin
            check("frame byte", 32'(rxByte), 32'(expByte));
            frameCount++;
            monBusy = 1'b0;
          end else begin
            monCnt++;
          end
        end
      end
    end
  end

  task automatic wrBus(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    wData  = d;
    wEn    = 1'b1;
    lastWr = cyc + 1;
    @(negedge clk);
    wEn    = 1'b0;
    addr   = 32'h100;
    wData  = '0;
  endtask

  task automatic wrTx(input logic [7:0] b, input bit keep);
    if (keep) sb.push_back(b);
    wrBus(TXA, {24'h0, b});
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitIdle(input string tag, input int maxCyc);
    int n;
    n = 0;
    while ((busy || monBusy) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, 32'(busy | monBusy), 32'd0);
  endtask

  task automatic readStat(input string tag, input logic [31:0] exp);
    addr = STA;
    #1;
    check(tag, rData, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    int e0;
    int fc0;

    repeat (2) @(negedge clk);
    readStat("reset status", 32'h0000_0004);
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: start bit one cycle after the write, busy low after the 41st edge.
    wrTx(8'h55, 1'b1);
    e0 = lastWr;
    waitCyc(e0 + 3);
    check("t1 start latency", lastStart, e0 + 1);
    waitCyc(e0 + 40);
    check("t1 busy in stop", 32'(busy), 32'd1);
    check("t1 tx stop", 32'(tx), 32'd1);
    @(negedge clk);
    check("t1 busy drop", 32'(busy), 32'd0);
    waitIdle("t1", 20);

    // Back-to-back frames, zero gap.
    wrTx(8'hA5, 1'b1);
    e0 = lastWr;
    wrTx(8'h3C, 1'b1);
    waitCyc(e0 + 3);
    check("t2 first start", lastStart, e0 + 1);
    waitCyc(e0 + 43);
    check("t2 second start", lastStart, e0 + 41);
    waitCyc(e0 + 81);
    readStat("t2 status", 32'h0000_0004);
    check("t2 hit", 32'(hit), 32'd1);
    waitIdle("t2", 20);

    // Overflow: six writes, sixth is dropped.
    fc0 = frameCount;
    for (int i = 0; i < 6; i++) begin
      wrTx(8'h10 + 8'(i), i < 5);
    end
    readStat("t3 full ovf", 32'h0000_040B);
    wrBus(STA, 32'h8);
    readStat("t3 ovf cleared", 32'h0000_0403);
    waitIdle("t3", 300);
    check("t3 frames", frameCount - fc0, 32'd5);

    // Full FIFO, push lands in the last STOP cycle alongside the pop.
    fc0 = frameCount;
    wrTx(8'h60, 1'b1);
    e0 = lastWr;
    for (int i = 1; i < 5; i++) begin
      wrTx(8'h60 + 8'(i), 1'b1);
    end
    waitCyc(e0 + 40);
    readStat("t4 full before", 32'h0000_0403);
    wrTx(8'h99, 1'b1);
    readStat("t4 full after", 32'h0000_0403);
    waitCyc(e0 + 43);
    check("t4 chained start", lastStart, e0 + 41);
    waitIdle("t4", 300);
    check("t4 frames", frameCount - fc0, 32'd6);

    // Reset during data bit 3, then a clean frame.
    wrTx(8'hAA, 1'b1);
    e0 = lastWr;
    waitCyc(e0 + 18);
    check("t5 busy before", 32'(busy), 32'd1);
    rst = 1'b0;
    readStat("t5 status in reset", 32'h0000_0004);
    check("t5 tx in reset", 32'(tx), 32'd1);
    check("t5 busy in reset", 32'(busy), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fc0 = frameCount;
    wrTx(8'hFF, 1'b1);
    e0 = lastWr;
    waitIdle("t5", 80);
    check("t5 restart start", lastStart, e0 + 1);
    check("t5 frames", frameCount - fc0, 32'd1);

    // Decode.
    readStat("t6 stat rData", 32'h0000_0004);
    check("t6 stat hit", 32'(hit), 32'd1);
    addr = 32'h100;
    #1;
    check("t6 other hit", 32'(hit), 32'd0);
    check("t6 other rData", rData, 32'd0);
    addr = TXA;
    #1;
    check("t6 tx hit", 32'(hit), 32'd1);
    check("t6 tx rData", rData, 32'd0);
    fc0 = frameCount;
    wrBus(32'hFFFF_FFF4, 32'h77);
    readStat("t6 no push", 32'h0000_0004);
    repeat (12) @(negedge clk);
    check("t6 no frame", frameCount - fc0, 32'd0);
    check("t6 not busy", 32'(busy), 32'd0);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
